im2col_conv_stream: RTL and testbench

- Parametrised successor to the fixed 3x3, 224x30 segmented-strip convolution unit.
- Consumes a raster-order pixel stream and holds K-1 line buffers plus a KxK window register, so no pixel is re-fetched.
- K*K parallel MACs, a pipelined adder tree and a post-process stage produce one output per valid window.
- Adds stride, requantisation shift, ReLU, saturation, ready/valid backpressure and kernel reuse across frames/strips.

---
 rtl/im2col_conv_stream.sv | 204 ++++++++++++++++++++
 tb/tb_im2col_conv_stream.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : im2col_conv_stream
// Function : Streaming KxK convolution: line buffers, window, K*K MACs, requant/ReLU/saturate
// Revision : 1.0
// ============================================================================
module im2col_conv_stream #(
    parameter int DATA_W = 9,
    parameter int K      = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 30,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_start,
    input  logic                     i_cfg_reuse_k,
    input  logic                     i_cfg_relu,
    input  logic [4:0]               i_cfg_shift,
    input  logic                     i_k_valid,
    input  logic signed [DATA_W-1:0] i_k_data,
    output logic                     o_k_ready,
    input  logic                     i_s_valid,
    input  logic signed [DATA_W-1:0] i_s_data,
    output logic                     o_s_ready,
    output logic                     o_m_valid,
    output logic signed [OUT_W-1:0]  o_m_data,
    output logic                     o_m_last,
    input  logic                     i_m_ready,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int c_NTAP     = K * K;
    localparam int c_PW       = 2 * DATA_W;
    localparam int c_OH       = (IMG_H - K) / STRIDE + 1;
    localparam int c_OW       = (IMG_W - K) / STRIDE + 1;
    localparam int c_LAST_ROW = (c_OH - 1) * STRIDE + K - 1;
    localparam int c_LAST_COL = (c_OW - 1) * STRIDE + K - 1;
    localparam int c_RW       = $clog2(IMG_H);
    localparam int c_CW       = $clog2(IMG_W);
    localparam int c_KW       = $clog2(c_NTAP);
    localparam logic c_KPAR   = 1'((K - 1) % 2);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [c_KW-1:0]           r_kcnt;
    logic [c_RW-1:0]           r_row;
    logic [c_CW-1:0]           r_col;
    logic                      r_relu;
    logic [4:0]                r_shift;
    logic                      r_last_seen;
    logic signed [DATA_W-1:0]  r_coef [c_NTAP];
    logic signed [DATA_W-1:0]  r_lb   [K-1][IMG_W];
    logic signed [DATA_W-1:0]  r_win  [c_NTAP];
    logic signed [c_PW-1:0]    r_prod [c_NTAP];
    logic signed [ACC_W-1:0]   r_sum;
    logic                      r_wv, r_wl, r_v1, r_l1, r_v2, r_l2;
    logic                      r_m_valid, r_m_last;
    logic signed [OUT_W-1:0]   r_m_data;

    logic                      w_en, w_s_hs, w_last_px, w_win_ok, w_win_last, w_mlast_hs;
    logic signed [DATA_W-1:0]  w_tap  [K];
    logic signed [c_PW-1:0]    w_prod [c_NTAP];
    logic signed [ACC_W-1:0]   w_sum, w_shr, w_rl;
    logic signed [OUT_W-1:0]   w_post;

    assign w_en       = !r_m_valid || i_m_ready;
    assign o_s_ready  = (r_state == S_RUN) && w_en;
    assign w_s_hs     = i_s_valid && o_s_ready;
    assign w_mlast_hs = r_m_valid && r_m_last && i_m_ready;
    assign w_last_px  = (r_row == c_RW'(IMG_H - 1)) && (r_col == c_CW'(IMG_W - 1));
    // With STRIDE 2 the offset from K-1 is even exactly when the parity matches (K-1)'s
    assign w_win_ok   = (r_row >= c_RW'(K - 1)) && (r_col >= c_CW'(K - 1)) &&
                        ((STRIDE == 1) || ((r_row[0] == c_KPAR) && (r_col[0] == c_KPAR)));
    assign w_win_last = (r_row == c_RW'(c_LAST_ROW)) && (r_col == c_CW'(c_LAST_COL));

    assign o_k_ready  = (r_state == S_LOAD_K);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_m_valid  = r_m_valid;
    assign o_m_data   = r_m_data;
    assign o_m_last   = r_m_last;

    always_comb begin
        w_tap[K-1] = i_s_data;
        for (int m = 1; m < K; m++) w_tap[K-1-m] = r_lb[m-1][IMG_W-1];
        for (int i = 0; i < c_NTAP; i++)
            w_prod[i] = {{DATA_W{r_coef[i][DATA_W-1]}}, r_coef[i]} *
                        {{DATA_W{r_win[i][DATA_W-1]}}, r_win[i]};
        w_sum = '0;
        for (int i = 0; i < c_NTAP; i++)
            w_sum = w_sum + {{(ACC_W-c_PW){r_prod[i][c_PW-1]}}, r_prod[i]};
        w_shr  = r_sum >>> r_shift;
        w_rl   = (r_relu && w_shr[ACC_W-1]) ? '0 : w_shr;
        w_post = w_rl[OUT_W-1:0];
        if (w_rl > c_SAT_MAX)      w_post = c_SAT_MAX[OUT_W-1:0];
        else if (w_rl < c_SAT_MIN) w_post = c_SAT_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_kcnt      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_relu      <= 1'b0;
            r_shift     <= '0;
            r_last_seen <= 1'b0;
            for (int i = 0; i < c_NTAP; i++) r_coef[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_relu      <= i_cfg_relu;
                    r_shift     <= i_cfg_shift;
                    r_last_seen <= 1'b0;
                    r_kcnt      <= '0;
                    r_row       <= '0;
                    r_col       <= '0;
                    r_state     <= i_cfg_reuse_k ? S_RUN : S_LOAD_K;
                end
                S_LOAD_K: if (i_k_valid) begin
                    r_coef[r_kcnt] <= i_k_data;
                    if (r_kcnt == c_KW'(c_NTAP - 1)) begin
                        r_kcnt  <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_kcnt <= r_kcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_s_hs) begin
                        if (w_last_px) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_DRAIN;
                        end else if (r_col == c_CW'(IMG_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    // The last window can leave before the final pixel when the stride skips trailing rows/cols
                    if (w_mlast_hs) r_last_seen <= 1'b1;
                end
                S_DRAIN: if (w_mlast_hs || r_last_seen) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < K - 1; m++)
                for (int j = 0; j < IMG_W; j++) r_lb[m][j] <= '0;
            for (int i = 0; i < c_NTAP; i++) begin
                r_win[i]  <= '0;
                r_prod[i] <= '0;
            end
            r_sum     <= '0;
            {r_wv, r_wl, r_v1, r_l1, r_v2, r_l2} <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_s_hs) begin
                for (int m = 0; m < K - 1; m++) begin
                    r_lb[m][0] <= w_tap[K-1-m];
                    for (int j = 1; j < IMG_W; j++) r_lb[m][j] <= r_lb[m][j-1];
                end
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) r_win[r*K+c] <= r_win[r*K+c+1];
                    r_win[r*K+K-1] <= w_tap[r];
                end
            end
            if (w_en) begin
                r_wv <= w_s_hs && w_win_ok;
                r_wl <= w_s_hs && w_win_ok && w_win_last;
                for (int i = 0; i < c_NTAP; i++) r_prod[i] <= w_prod[i];
                r_v1      <= r_wv;
                r_l1      <= r_wl;
                r_sum     <= w_sum;
                r_v2      <= r_v1;
                r_l2      <= r_l1;
                r_m_valid <= r_v2;
                r_m_last  <= r_l2;
                if (r_v2) r_m_data <= w_post;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_im2col_conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_im2col_conv_stream
// Function : Scoreboard bench on a 5x4 stride-1 and a 5x5 stride-2 instance
// Revision : 1.0
// ============================================================================
module tb_im2col_conv_stream;
    localparam int DW = 9;
    localparam int OW = 16;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic a_start, b_start, cfg_reuse_k, cfg_relu;
    logic [4:0] cfg_shift;
    logic k_valid, s_valid, m_ready;
    logic signed [DW-1:0] k_data, s_data;
    logic a_k_ready, a_s_ready, a_m_valid, a_m_last, a_busy, a_done;
    logic b_k_ready, b_s_ready, b_m_valid, b_m_last, b_busy, b_done;
    logic signed [OW-1:0] a_m_data, b_m_data;
    logic w_kr, w_sr, w_mv, w_ml, w_busy, w_done;
    logic signed [OW-1:0] w_md;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_mv = -1;
    int sel = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    im2col_conv_stream #(.DATA_W(DW), .K(3), .IMG_W(5), .IMG_H(4), .STRIDE(1), .ACC_W(32), .OUT_W(OW)) u_a (
        .clk(clk), .reset_n(reset_n), .i_start(a_start), .i_cfg_reuse_k(cfg_reuse_k),
        .i_cfg_relu(cfg_relu), .i_cfg_shift(cfg_shift), .i_k_valid(k_valid), .i_k_data(k_data),
        .o_k_ready(a_k_ready), .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(a_s_ready),
        .o_m_valid(a_m_valid), .o_m_data(a_m_data), .o_m_last(a_m_last), .i_m_ready(m_ready),
        .o_busy(a_busy), .o_done(a_done));

    im2col_conv_stream #(.DATA_W(DW), .K(3), .IMG_W(5), .IMG_H(5), .STRIDE(2), .ACC_W(32), .OUT_W(OW)) u_b (
        .clk(clk), .reset_n(reset_n), .i_start(b_start), .i_cfg_reuse_k(cfg_reuse_k),
        .i_cfg_relu(cfg_relu), .i_cfg_shift(cfg_shift), .i_k_valid(k_valid), .i_k_data(k_data),
        .o_k_ready(b_k_ready), .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(b_s_ready),
        .o_m_valid(b_m_valid), .o_m_data(b_m_data), .o_m_last(b_m_last), .i_m_ready(m_ready),
        .o_busy(b_busy), .o_done(b_done));

    always_comb begin
        if (sel == 0) {w_kr, w_sr, w_mv, w_ml, w_busy, w_done, w_md} =
                      {a_k_ready, a_s_ready, a_m_valid, a_m_last, a_busy, a_done, a_m_data};
        else          {w_kr, w_sr, w_mv, w_ml, w_busy, w_done, w_md} =
                      {b_k_ready, b_s_ready, b_m_valid, b_m_last, b_busy, b_done, b_m_data};
    end

    // Output monitor: every accepted beat is popped from the scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic signed [OW-1:0] ed;
        if (reset_n) begin
            if (w_mv && first_mv < 0) first_mv = cyc;
            if (w_mv && !m_ready) begin
                checks++;
                if (w_sr !== 1'b0) begin
                    errors++;
                    $display("FAIL s_ready_under_stall: got %b want 0", w_sr);
                end
            end
            if (w_mv && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %0d last %b, scoreboard empty", w_md, w_ml);
                end else begin
                    e  = q.pop_front();
                    ed = e.data[OW-1:0];
                    if (w_md !== ed || w_ml !== e.last) begin
                        errors++;
                        $display("FAIL beat: got data %0d last %b want data %0d last %b", w_md, w_ml, ed, e.last);
                    end
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rand_ready && $urandom_range(0, 3) == 0) begin
                m_ready = 1'b0;
                repeat ($urandom_range(1, 10)) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_model(input int w, input int h, input int st, input int coef[], input int pix[],
                              input int shift, input bit relu);
        int oh, ow;
        longint acc;
        oh = (h - 3) / st + 1;
        ow = (w - 3) / st + 1;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += longint'(coef[i*3+j]) * longint'(pix[(r*st+i)*w + c*st+j]);
                acc = acc >>> shift;
                if (relu && acc < 0) acc = 0;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                q.push_back(exp_t'{int'(acc), (r == oh - 1 && c == ow - 1)});
            end
    endtask

    task automatic run_frame(input int s, input bit reuse, input bit relu, input int shift,
                             input int coef[], input int pix[], input bit gaps, input int mark_idx,
                             input int abort_after, output int ndone, output int nkr,
                             output int mark_cyc, output bit tmo);
        bit hs;
        int n;
        ndone = 0; nkr = 0; mark_cyc = -1; tmo = 1'b0; first_mv = -1;
        @(posedge clk); #1;
        cfg_reuse_k = reuse; cfg_relu = relu; cfg_shift = 5'(shift);
        if (s == 0) a_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        if (!reuse) begin
            for (int i = 0; i < 9; i++) begin
                k_valid = 1'b1; k_data = DW'(coef[i]);
                n = 0;
                do begin
                    @(negedge clk); hs = w_kr;
                    @(posedge clk); #1; n++;
                end while (!hs && n < 50);
                if (!hs) tmo = 1'b1;
            end
            k_valid = 1'b0;
        end
        for (int i = 0; i < pix.size(); i++) begin
            if (abort_after >= 0 && i == abort_after) begin
                s_valid = 1'b0;
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1; s_data = DW'(pix[i]);
            n = 0;
            do begin
                @(negedge clk); hs = w_sr;
                if (w_kr) nkr++;
                if (hs && i == mark_idx) mark_cyc = cyc + 1;
                @(posedge clk); #1; n++;
            end while (!hs && n < 200);
            if (!hs) tmo = 1'b1;
        end
        s_valid = 1'b0;
        n = 0;
        while ((w_busy || q.size() != 0) && n < 1000) begin
            @(negedge clk);
            if (w_done) ndone++;
            if (w_kr) nkr++;
            n++;
        end
        if (n >= 1000) tmo = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (w_done) ndone++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_k_ready, a_s_ready, a_m_valid, a_m_last, a_busy, a_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b want 000000", {a_k_ready, a_s_ready, a_m_valid, a_m_last, a_busy, a_done});
        end
        checks++;
        if (a_m_data !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data_a: got %0d want 0", a_m_data);
        end
        checks++;
        if ({b_k_ready, b_s_ready, b_m_valid, b_m_last, b_busy, b_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_b: got %b want 000000", {b_k_ready, b_s_ready, b_m_valid, b_m_last, b_busy, b_done});
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_k_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy %b k_ready %b want 0 0", a_busy, a_k_ready);
        end
    endtask

    task automatic test_centre();
        int coef[], pix[], expv[6];
        int nd, nk, mc;
        bit tmo;
        expv = '{6, 7, 8, 11, 12, 13};
        coef = new[9]; pix = new[20];
        foreach (coef[i]) coef[i] = (i == 4) ? 1 : 0;
        foreach (pix[i]) pix[i] = i;
        sel = 0;
        for (int i = 0; i < 6; i++) q.push_back(exp_t'{expv[i], (i == 5)});
        run_frame(0, 1'b0, 1'b0, 0, coef, pix, 1'b0, 12, -1, nd, nk, mc, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL centre_timeout: got timeout want none"); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL centre_done_pulses: got %0d want 1", nd); end
        checks++;
        if (first_mv - mc !== 3) begin errors++; $display("FAIL centre_latency: got %0d want 3", first_mv - mc); end
        checks++;
        if (q.size() !== 0) begin errors++; $display("FAIL centre_missing: got %0d left want 0", q.size()); end
        q.delete();
    endtask

    task automatic test_saturation();
        int coef[], pix[];
        int nd, nk, mc, cv, ev;
        bit tmo;
        coef = new[9]; pix = new[20];
        sel = 0;
        for (int t = 0; t < 2; t++) begin
            cv = (t == 0) ? 255 : -256;
            ev = (t == 0) ? 32767 : -32768;
            foreach (coef[i]) coef[i] = cv;
            foreach (pix[i]) pix[i] = 255;
            for (int i = 0; i < 6; i++) q.push_back(exp_t'{ev, (i == 5)});
            run_frame(0, 1'b0, 1'b0, 0, coef, pix, 1'b0, -1, -1, nd, nk, mc, tmo);
            checks++;
            if (tmo || nd !== 1) begin errors++; $display("FAIL sat_frame_%0d: got timeout %b done %0d want 0 1", t, tmo, nd); end
            checks++;
            if (q.size() !== 0) begin errors++; $display("FAIL sat_missing_%0d: got %0d left want 0", t, q.size()); end
            q.delete();
        end
    endtask

    task automatic test_shift_relu();
        int coef[], pix[], relu_v[3], shift_v[3], exp_v[3];
        int nd, nk, mc;
        bit tmo;
        relu_v = '{0, 0, 1}; shift_v = '{0, 2, 0}; exp_v = '{-9, -3, 0};
        coef = new[9]; pix = new[20];
        foreach (coef[i]) coef[i] = -1;
        foreach (pix[i]) pix[i] = 1;
        sel = 0;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 6; i++) q.push_back(exp_t'{exp_v[t], (i == 5)});
            run_frame(0, (t != 0), relu_v[t][0], shift_v[t], coef, pix, 1'b0, -1, -1, nd, nk, mc, tmo);
            checks++;
            if (tmo || nd !== 1) begin errors++; $display("FAIL shift_relu_frame_%0d: got timeout %b done %0d want 0 1", t, tmo, nd); end
            checks++;
            if (q.size() !== 0) begin errors++; $display("FAIL shift_relu_missing_%0d: got %0d left want 0", t, q.size()); end
            q.delete();
        end
    endtask

    task automatic test_stride2();
        int coef[], pix[], expv[4];
        int nd, nk, mc;
        bit tmo;
        expv = '{6, 8, 16, 18};
        coef = new[9]; pix = new[25];
        foreach (coef[i]) coef[i] = (i == 4) ? 1 : 0;
        foreach (pix[i]) pix[i] = i;
        sel = 1;
        for (int i = 0; i < 4; i++) q.push_back(exp_t'{expv[i], (i == 3)});
        run_frame(1, 1'b0, 1'b0, 0, coef, pix, 1'b0, -1, -1, nd, nk, mc, tmo);
        checks++;
        if (tmo || nd !== 1) begin errors++; $display("FAIL stride2_frame: got timeout %b done %0d want 0 1", tmo, nd); end
        checks++;
        if (q.size() !== 0) begin errors++; $display("FAIL stride2_missing: got %0d left want 0", q.size()); end
        q.delete();
        sel = 0;
    endtask

    task automatic test_back_to_back();
        int coef[], pix[];
        int nd, nk, mc, sh;
        bit tmo, rl;
        coef = new[9]; pix = new[20];
        sel = 0;
        rand_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            foreach (coef[i]) coef[i] = int'($urandom_range(0, 511)) - 256;
            foreach (pix[i]) pix[i] = int'($urandom_range(0, 511)) - 256;
            sh = int'($urandom_range(0, 6));
            rl = 1'($urandom_range(0, 1));
            push_model(5, 4, 1, coef, pix, sh, rl);
            run_frame(0, 1'b0, rl, sh, coef, pix, 1'b1, -1, -1, nd, nk, mc, tmo);
            checks++;
            if (tmo || nd !== 1) begin errors++; $display("FAIL stall_frame_%0d: got timeout %b done %0d want 0 1", t, tmo, nd); end
            checks++;
            if (q.size() !== 0) begin errors++; $display("FAIL stall_missing_%0d: got %0d left want 0", t, q.size()); end
            q.delete();
        end
        rand_ready = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int coef[], zc[], pix[];
        int nd, nk, mc;
        bit tmo;
        coef = new[9]; zc = new[9]; pix = new[20];
        foreach (coef[i]) coef[i] = i + 1;
        foreach (zc[i]) zc[i] = 0;
        foreach (pix[i]) pix[i] = 3 * i - 20;
        sel = 0;
        run_frame(0, 1'b0, 1'b0, 0, coef, pix, 1'b0, -1, 10, nd, nk, mc, tmo);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk) reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: got done %b busy %b want 0 0", a_done, a_busy);
            end
        end
        push_model(5, 4, 1, zc, pix, 0, 1'b0);
        run_frame(0, 1'b1, 1'b0, 0, zc, pix, 1'b0, -1, -1, nd, nk, mc, tmo);
        checks++;
        if (tmo || nd !== 1) begin errors++; $display("FAIL cleared_kernel_frame: got timeout %b done %0d want 0 1", tmo, nd); end
        checks++;
        if (q.size() !== 0) begin errors++; $display("FAIL cleared_kernel_missing: got %0d left want 0", q.size()); end
        q.delete();
        for (int t = 0; t < 2; t++) begin
            push_model(5, 4, 1, coef, pix, 1, 1'b0);
            run_frame(0, (t == 1), 1'b0, 1, coef, pix, 1'b0, -1, -1, nd, nk, mc, tmo);
            checks++;
            if (tmo || nd !== 1) begin errors++; $display("FAIL reuse_frame_%0d: got timeout %b done %0d want 0 1", t, tmo, nd); end
            checks++;
            if (q.size() !== 0) begin errors++; $display("FAIL reuse_missing_%0d: got %0d left want 0", t, q.size()); end
            q.delete();
        end
        checks++;
        if (nk !== 0) begin errors++; $display("FAIL reuse_k_ready: got %0d high cycles want 0", nk); end
    endtask

    initial begin
        reset_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        cfg_reuse_k = 1'b0; cfg_relu = 1'b0; cfg_shift = 5'd0;
        k_valid = 1'b0; k_data = '0; s_valid = 1'b0; s_data = '0;
        test_reset();
        test_centre();
        test_saturation();
        test_shift_relu();
        test_stride2();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
